// File: rtl/addsub_pipe_cla.sv
// Pipelined two's-complement adder/subtractor built from GROUP-bit carry-lookahead
// slices, one slice per stage, with valid/ready flow control and optional signed saturation.
module addsub_pipe_cla #(
  parameter int WIDTH = 16,  // multiple of GROUP, at least 2*GROUP
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovr,
  output logic             neg,
  output logic             zero
);

  localparam int STAGES = WIDTH / GROUP;

  // Handshake: an operation enters on in_valid & in_ready and leaves on
  // out_valid & out_ready. The whole pipeline advances as one unit whenever the
  // output register is empty or being drained, so in_ready is that same condition.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Lookahead carries for one slice; c[i] is the carry into bit i, c[GROUP] the carry out.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic ci);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             prod;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & ci);
    end
    return c;
  endfunction

  // Stage k register holds the operands (b already conditioned by m), the carry
  // into slice k and the result slices below it.
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sat_q [STAGES];

  logic [GROUP:0]   cv     [STAGES];
  logic [WIDTH-1:0] nxt_s  [STAGES];
  logic             nxt_c  [STAGES];
  logic             nxt_cm [STAGES];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      cv[k]     = cla_carries(a_q[k][k*GROUP +: GROUP], b_q[k][k*GROUP +: GROUP], c_q[k]);
      nxt_s[k]  = s_q[k];
      nxt_s[k][k*GROUP +: GROUP] = a_q[k][k*GROUP +: GROUP] ^ b_q[k][k*GROUP +: GROUP]
                                   ^ cv[k][GROUP-1:0];
      nxt_c[k]  = cv[k][GROUP];
      nxt_cm[k] = cv[k][GROUP-1];
    end
  end

  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] fin_s;
  logic             fin_cout;
  logic             fin_ovr;

  // Raw MSB set on overflow means two positives wrapped negative, so clamp to max.
  always_comb begin
    raw_s    = nxt_s[STAGES-1];
    fin_cout = nxt_c[STAGES-1];
    fin_ovr  = nxt_cm[STAGES-1] ^ nxt_c[STAGES-1];
    fin_s    = raw_s;
    if (sat_q[STAGES-1] && fin_ovr) begin
      fin_s = raw_s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovr       <= 1'b0;
      neg       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      v_q[0]   <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= b ^ {WIDTH{m}};
      c_q[0]   <= m;
      s_q[0]   <= '0;
      sat_q[0] <= sat;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]   <= v_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        c_q[k]   <= nxt_c[k-1];
        s_q[k]   <= nxt_s[k-1];
        sat_q[k] <= sat_q[k-1];
      end
      out_valid <= v_q[STAGES-1];
      // Bubbles leave the last result in place rather than loading junk.
      if (v_q[STAGES-1]) begin
        s    <= fin_s;
        cout <= fin_cout;
        ovr  <= fin_ovr;
        neg  <= fin_s[WIDTH-1];
        zero <= (fin_s == '0);
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe_cla.sv
// Self-checking bench for addsub_pipe_cla: directed corner vectors, stall and reset
// scenarios, then randomized traffic against an integer-arithmetic reference model.
module tb_addsub_pipe_cla;

  localparam int WIDTH  = 16;
  localparam int GROUP  = 4;
  localparam int STAGES = WIDTH / GROUP;
  localparam int RW     = WIDTH + 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             m = 1'b0;
  logic             sat = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] s;
  logic             cout, ovr, neg, zero;

  logic [RW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            stall_cycles = 0;
  logic          rand_mode = 1'b0;
  logic          force_ready = 1'b1;

  always #5 clk = ~clk;

  addsub_pipe_cla #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovr(ovr), .neg(neg), .zero(zero)
  );

  // Reference: signed/unsigned results from plain integer arithmetic.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                          input logic mm, input logic ss);
    longint sx, sy, ux, uy, t, maxp, minn;
    logic o, c;
    logic [WIDTH-1:0] r;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    ux   = longint'(x);
    uy   = longint'(y);
    maxp = (longint'(1) << (WIDTH - 1)) - 1;
    minn = -maxp - 1;
    t    = mm ? (sx - sy) : (sx + sy);
    o    = (t > maxp) || (t < minn);
    c    = mm ? (ux >= uy) : (((ux + uy) >> WIDTH) != 0);
    if (ss && o) r = (t > 0) ? maxp[WIDTH-1:0] : minn[WIDTH-1:0];
    else         r = t[WIDTH-1:0];
    return {r, c, o, r[WIDTH-1], (r == '0)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  // Sink: out_ready changes only well after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  end

  // Monitor: pops expected results on every output transfer, checks stalls hold.
  logic          stalled = 1'b0;
  logic [RW-1:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {out_valid, s, cout, ovr, neg, zero}, {1'b1, held});
      if (out_valid && !out_ready) begin
        stall_cycles++;
        check("in_ready_during_stall", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got s=%h with no operation outstanding", s);
        end else begin
          check("result", {s, cout, ovr, neg, zero}, exp_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held    = {s, cout, ovr, neg, zero};
    end
  end

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                      input logic tm, input logic ts);
    int   waited = 0;
    logic acc = 1'b0;
    in_valid = 1'b1; a = ta; b = tb_v; m = tm; sat = ts;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(model(ta, tb_v, tm, ts));
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 20);
    check(name, n, STAGES);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b0, {(WIDTH-1){1'b1}}};
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog: got timeout expected run to complete");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", {s, cout, ovr, neg, zero}, 0);
    check("reset_in_ready", in_ready, 1);

    // Corner vectors
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    lat_check("latency");
    drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0005, 1'b1, 1'b0);
    send(16'h006C, 16'h00CA, 1'b1, 1'b0);
    drain();

    // Six back-to-back ops with a three-cycle stall once results appear
    stall_cycles = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1 force_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 force_ready = 1'b1;
      end
    join
    drain();
    check("stall_observed", stall_cycles >= 3, 1);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_outputs", {s, cout, ovr, neg, zero}, 0);
    check("midreset_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    send(16'h1234, 16'h0FED, 1'b0, 1'b0);
    lat_check("latency_after_reset");
    drain();

    // Randomized traffic with random backpressure and input gaps
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom), 1'($urandom));
    end
    rand_mode = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
